spi_master_reg_access: RTL and testbench

- SPI master that initiates register bursts toward the FPGA's SPI-slave register bridge. Used by the test/host-side controller logic.
- Frame format:
  - Write: CS low, then byte 0x80|addr, then N data bytes, then CS high.
  - Read: CS low, then byte addr, then N dummy 0xFF bytes; MISO returns data for addr, addr+1, … during the dummy bytes; then CS high.
- Accepts one command at a time on a valid/ready port, streams write bytes in, and pulses read bytes out.

---
 rtl/spi_master_reg_access_if.sv | 48 ++++
 rtl/spi_master_reg_access.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_master_reg_access.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_reg_access_if.sv
// Host-side command/data port of the SPI register-burst master.
// Holds the command, write-byte, read-byte, done and error signals.
interface spi_master_reg_access_if #(
  parameter int LEN_W = 8
) ();
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_write_i;
  logic [6:0]       cmd_addr_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             wr_valid_i;
  logic [7:0]       wr_data_i;
  logic             wr_ready_o;
  logic             rd_valid_o;
  logic [7:0]       rd_data_o;
  logic             done_o;
  logic             err_o;

  modport slave (
    input  cmd_valid_i,
    input  cmd_write_i,
    input  cmd_addr_i,
    input  cmd_len_i,
    input  wr_valid_i,
    input  wr_data_i,
    output cmd_ready_o,
    output wr_ready_o,
    output rd_valid_o,
    output rd_data_o,
    output done_o,
    output err_o
  );

  modport master (
    output cmd_valid_i,
    output cmd_write_i,
    output cmd_addr_i,
    output cmd_len_i,
    output wr_valid_i,
    output wr_data_i,
    input  cmd_ready_o,
    input  wr_ready_o,
    input  rd_valid_o,
    input  rd_data_o,
    input  done_o,
    input  err_o
  );
endinterface

// File: rtl/spi_master_reg_access.sv
// SPI mode-0 master issuing register read/write bursts to a slave bridge.
// Optional SPI_MASTER_WRAP_CHECK_EN rejects bursts that cross 0x7F.
module spi_master_reg_access #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_CYC  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8,
  parameter int LEN_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  spi_master_reg_access_if.slave host,
  output logic                  spi_ssel_o,
  output logic                  spi_sck_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD,
    ST_CS_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx;
  logic             r_write;
  logic             r_data_ph;
  logic [LEN_W-1:0] r_rem;
  logic             r_ssel;
  logic             r_sck;
  logic             r_mosi;
  logic             r_rd_valid;
  logic [7:0]       r_rd_data;
  logic             r_done;

  logic             w_accept;
  logic             w_load;
  logic             w_wr_take;
  logic             w_tick;
  logic             w_rise;
  logic             w_fall;
  logic             w_byte_end;
  logic             w_enter_shift;
  logic [7:0]       w_next_byte;

`ifdef SPI_MASTER_WRAP_CHECK_EN
  localparam int SUM_W = LEN_W + 8;
  logic             w_over;
  logic             w_reject;
  logic             r_err;
  logic [SUM_W-1:0] w_sum;

  assign w_sum  = SUM_W'(host.cmd_addr_i) + SUM_W'(host.cmd_len_i);
  assign w_over = (w_sum > SUM_W'(128));
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_CS_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_load        = 1'b0;
    w_wr_take     = 1'b0;
    w_tick        = (r_div == CNT_W'(CLK_DIV - 1));
    w_rise        = (r_state == ST_SHIFT) && w_tick && !r_sck;
    w_fall        = (r_state == ST_SHIFT) && w_tick && r_sck;
    w_byte_end    = w_fall && (r_bit == 3'd7);
    w_next_byte   = r_write ? host.wr_data_i : 8'hFF;
`ifdef SPI_MASTER_WRAP_CHECK_EN
    w_reject      = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (host.cmd_valid_i) begin
`ifdef SPI_MASTER_WRAP_CHECK_EN
          if (w_over) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_SETUP;
          end
`else
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
`endif
        end
      end
      ST_SETUP: begin
        if (r_cnt == CNT_W'(CS_SETUP - 1)) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_byte_end) begin
          w_state_nxt = (r_rem == '0) ? ST_HOLD : ST_GAP;
        end
      end
      ST_GAP: begin
        // Counter saturates, so a write stall just waits here.
        if (r_cnt >= CNT_W'(GAP_CYC - 1) &&
            (!r_write || host.wr_valid_i)) begin
          w_load      = 1'b1;
          w_wr_take   = r_write;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (r_cnt == CNT_W'(CS_HOLD - 1)) w_state_nxt = ST_CS_WAIT;
      end
      ST_CS_WAIT: begin
        if (r_cnt == CNT_W'(CS_IDLE - 1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_enter_shift = (r_state != ST_SHIFT) && (w_state_nxt == ST_SHIFT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_write    <= 1'b0;
      r_data_ph  <= 1'b0;
      r_rem      <= '0;
      r_ssel     <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_write   <= host.cmd_write_i;
        r_tx      <= {host.cmd_write_i, host.cmd_addr_i};
        r_rem     <= host.cmd_len_i;
        r_data_ph <= 1'b0;
        r_ssel    <= 1'b0;
      end
      if (w_enter_shift) begin
        r_div <= '0;
        r_bit <= '0;
      end
      if (w_enter_shift && !w_load) begin
        r_mosi <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      if (w_load) begin
        r_mosi    <= w_next_byte[7];
        r_tx      <= {w_next_byte[6:0], 1'b0};
        r_rem     <= r_rem - LEN_W'(1);
        r_data_ph <= 1'b1;
      end
      if (r_state == ST_SHIFT) begin
        r_div <= w_tick ? '0 : r_div + CNT_W'(1);
        if (w_tick) r_sck <= ~r_sck;
        if (w_rise) r_rx <= {r_rx[6:0], spi_miso_i};
        if (w_fall && !w_byte_end) begin
          r_mosi <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
          r_bit  <= r_bit + 3'd1;
        end
        if (w_byte_end && r_data_ph && !r_write) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= r_rx;
        end
      end
      if (r_state == ST_HOLD && w_state_nxt == ST_CS_WAIT) begin
        r_ssel <= 1'b1;
        r_done <= 1'b1;
        r_mosi <= 1'b0;
      end
    end
  end

`ifdef SPI_MASTER_WRAP_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
    end
  end

  assign host.err_o = r_err;
`else
  assign host.err_o = 1'b0;
`endif

  assign host.cmd_ready_o = (r_state == ST_IDLE);
  assign host.wr_ready_o  = w_wr_take;
  assign host.rd_valid_o  = r_rd_valid;
  assign host.rd_data_o   = r_rd_data;
  assign host.done_o      = r_done;
  assign spi_ssel_o       = r_ssel;
  assign spi_sck_o        = r_sck;
  assign spi_mosi_o       = r_mosi;

endmodule

// File: tb/tb_spi_master_reg_access.sv
// Bench for spi_master_reg_access: command table, SPI slave model
// with register file, and queue scoreboards for MOSI and read bytes.
module tb_spi_master_reg_access;

  typedef struct {
    logic        write;
    logic [6:0]  addr;
    int          len;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_cyc;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic spi_ssel;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_sck = 0, n_csfall = 0, n_csrise = 0;
  int n_wr = 0, n_rd = 0, n_done = 0, n_err = 0;

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_q[$];
  logic       wr_took = 1'b0;

  logic [7:0] regs[128];
  logic [6:0] s_addr = '0;
  logic [7:0] s_rx = '0;
  logic [7:0] s_tx = 8'hEE;
  int         s_bit = 0;
  int         s_idx = 0;
  logic       p_sck = 1'b0;
  logic       p_ssel = 1'b1;

  vec_t vecs[5];

  spi_master_reg_access_if #(.LEN_W(8)) bus ();

  spi_master_reg_access dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .host       (bus),
    .spi_ssel_o (spi_ssel),
    .spi_sck_o  (spi_sck),
    .spi_mosi_o (spi_mosi),
    .spi_miso_i (spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] slave_byte(input int idx);
    if (idx == 0) return 8'hEE;
    return regs[7'(int'(s_addr) + idx - 1)];
  endfunction

  function automatic vec_t mk(input logic w, input logic [6:0] a,
                              input int l, input logic [31:0] d,
                              input logic [31:0] e, input int c);
    vec_t v;
    v.write = w; v.addr = a; v.len = l;
    v.data = d; v.exp_rd = e; v.exp_cyc = c;
    return v;
  endfunction

  // SPI slave: MISO shifted out on falling SCK, MOSI captured on rising
  always @(spi_sck or spi_ssel) begin
    if (!spi_ssel && p_ssel) begin
      n_csfall++;
      s_bit = 0;
      s_idx = 0;
      s_tx = slave_byte(0);
      spi_miso = s_tx[7];
    end
    if (spi_ssel && !p_ssel) n_csrise++;
    if (spi_sck && !p_sck) begin
      n_sck++;
      chk("sck_while_cs_low", spi_ssel, 1'b0);
      s_rx = {s_rx[6:0], spi_mosi};
      s_bit++;
      if (s_bit == 8) begin
        s_bit = 0;
        if (s_idx == 0) s_addr = s_rx[6:0];
        if (exp_mosi.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mosi_extra: got %02h expected none", s_rx);
        end else begin
          chk("mosi_byte", s_rx, exp_mosi.pop_front());
        end
        s_idx++;
      end
    end
    if (!spi_sck && p_sck) begin
      if (s_bit == 0) begin
        s_tx = slave_byte(s_idx);
        spi_miso = s_tx[7];
      end else begin
        spi_miso = s_tx[7-s_bit];
      end
    end
    p_sck = spi_sck;
    p_ssel = spi_ssel;
  end

  always @(negedge clk) begin
    if (wr_took) void'(wr_q.pop_front());
    bus.wr_valid_i = (wr_q.size() != 0);
    bus.wr_data_i  = (wr_q.size() != 0) ? wr_q[0] : 8'h00;
    #1;
    wr_took = bus.wr_valid_i && bus.wr_ready_o;
    if (wr_took) n_wr++;
  end

  always @(negedge clk) begin
    if (bus.rd_valid_o) begin
      n_rd++;
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra: got %02h expected none", bus.rd_data_o);
      end else begin
        chk("rd_data", bus.rd_data_o, exp_rd.pop_front());
      end
    end
    if (bus.done_o) n_done++;
    if (bus.err_o) n_err++;
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus.cmd_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready", bus.cmd_ready_o, 1'b1);
  endtask

  task automatic issue(input logic w, input logic [6:0] a, input int l);
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_len_i   = 8'(l);
    bus.cmd_valid_i = 1'b1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    int t = 0;
    while (!bus.done_o && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", bus.done_o, 1'b1);
    done_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_cmd(input vec_t v);
    int acc, dc, d0, w0, r0, k0, f0, u0;
    wait_ready();
`ifdef SPI_MASTER_WRAP_CHECK_EN
    if (int'(v.addr) + v.len > 128) begin
      f0 = n_csfall;
      d0 = n_done;
      issue(v.write, v.addr, v.len);
      chk("err_pulse", bus.err_o, 1'b1);
      @(negedge clk);
      chk("err_single", bus.err_o, 1'b0);
      chk("ready_after_err", bus.cmd_ready_o, 1'b1);
      repeat (20) @(negedge clk);
      chk("err_no_cs", n_csfall - f0, 0);
      chk("err_no_done", n_done - d0, 0);
      return;
    end
`endif
    exp_mosi.push_back({v.write, v.addr});
    for (int k = 0; k < v.len; k++) begin
      if (v.write) begin
        exp_mosi.push_back(v.data[31-8*k -: 8]);
        wr_q.push_back(v.data[31-8*k -: 8]);
      end else begin
        exp_mosi.push_back(8'hFF);
        exp_rd.push_back(v.exp_rd[31-8*k -: 8]);
      end
    end
    d0 = n_done; w0 = n_wr; r0 = n_rd;
    k0 = n_sck; f0 = n_csfall; u0 = n_csrise;
    acc = cyc;
    issue(v.write, v.addr, v.len);
    wait_done(dc);
    chk("frame_cycles", dc - acc, v.exp_cyc);
    chk("sck_pulses", n_sck - k0, 8 * (v.len + 1));
    chk("wr_pulses", n_wr - w0, v.write ? v.len : 0);
    chk("rd_pulses", n_rd - r0, v.write ? 0 : v.len);
    chk("done_pulses", n_done - d0, 1);
    chk("cs_fall", n_csfall - f0, 1);
    chk("cs_rise", n_csrise - u0, 1);
    chk("mosi_left", exp_mosi.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
  endtask

  initial begin
    int c0, acc, dc, t, bad, s0, w0, d0, r0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_len_i   = '0;
    for (int i = 0; i < 128; i++) regs[i] = 8'(i) ^ 8'h5A;
    regs[7'h10] = 8'h11; regs[7'h11] = 8'h22; regs[7'h12] = 8'h33;
    regs[7'h7E] = 8'hA1; regs[7'h7F] = 8'hB2; regs[7'h00] = 8'hC3;
    vecs[0] = mk(1'b1, 7'h05, 2, 32'hA53C_0000, 32'h0, 217);
    vecs[1] = mk(1'b0, 7'h10, 3, 32'h0, 32'h1122_3300, 289);
    vecs[2] = mk(1'b0, 7'h7F, 0, 32'h0, 32'h0, 73);
    vecs[3] = mk(1'b1, 7'h40, 1, 32'h9600_0000, 32'h0, 145);
    vecs[4] = mk(1'b0, 7'h7E, 3, 32'h0, 32'hA1B2_C300, 289);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ssel", spi_ssel, 1'b1);
    chk("rst_sck", spi_sck, 1'b0);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_ready", bus.cmd_ready_o, 1'b0);
    chk("rst_rd_valid", bus.rd_valid_o, 1'b0);
    chk("rst_rd_data", bus.rd_data_o, 8'h00);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    rst_n = 1'b1;
    c0 = cyc;
    t = 0;
    while (!bus.cmd_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_after_por", cyc - c0, 8);

    for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

    // write with the second data byte withheld
    wait_ready();
    exp_mosi.push_back(8'hB0);
    exp_mosi.push_back(8'h5A);
    exp_mosi.push_back(8'hC3);
    wr_q.push_back(8'h5A);
    w0 = n_wr; d0 = n_done; s0 = n_sck;
    acc = cyc;
    issue(1'b1, 7'h30, 2);
    t = 0;
    while (n_wr - w0 < 1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (64 + 8 + 4) @(negedge clk);
    s0 = n_sck;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (spi_ssel !== 1'b0 || spi_sck !== 1'b0) bad++;
    end
    chk("stall_sck_edges", n_sck - s0, 0);
    chk("stall_pins", bad, 0);
    chk("stall_wr_count", n_wr - w0, 1);
    wr_q.push_back(8'hC3);
    wait_done(dc);
    chk("stall_long", (dc - acc) >= 217 + 50, 1'b1);
    chk("stall_wr_total", n_wr - w0, 2);
    chk("stall_done", n_done - d0, 1);
    chk("stall_mosi_left", exp_mosi.size(), 0);

    // reset in the middle of a read's address byte
    wait_ready();
    d0 = n_done; r0 = n_rd; s0 = n_sck;
    issue(1'b0, 7'h10, 3);
    t = 0;
    while (n_sck - s0 < 3 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_shift_reached", n_sck - s0, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ssel", spi_ssel, 1'b1);
    chk("midrst_sck", spi_sck, 1'b0);
    chk("midrst_ready", bus.cmd_ready_o, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    t = 0;
    while (!bus.cmd_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_after_midrst", cyc - c0, 8);
    chk("midrst_no_rd", n_rd - r0, 0);
    chk("midrst_no_done", n_done - d0, 0);

`ifndef SPI_MASTER_WRAP_CHECK_EN
    chk("err_never", n_err, 0);
`endif
    chk("final_mosi_q", exp_mosi.size(), 0);
    chk("final_rd_q", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
